// File: rtl/pe_mac_drain.sv
// pe_mac_drain: output-stationary systolic MAC PE with saturating accumulator and ready/valid drain chain
module pe_mac_drain #(
  parameter int D_W      = 32,
  parameter int D_W_ACC  = 64,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_in,
  input  logic [D_W-1:0]     in_a,
  input  logic [D_W-1:0]     in_b,
  input  logic               init,
  input  logic               flush,
  output logic               op_valid_out,
  output logic [D_W-1:0]     out_a,
  output logic [D_W-1:0]     out_b,
  input  logic [D_W_ACC-1:0] in_data,
  input  logic               in_sat,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [D_W_ACC-1:0] out_data,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [D_W_ACC-1:0] acc, res_data, ext_a, ext_b, prod, sum_w, clamp, acc_add;
  logic [D_W_ACC:0]   sum;
  logic               tile_sat, res_sat, res_pending;
  logic               ovf, start, close, accum, free, take_res;
  // Operands are widened in the selected mode so one modular multiply serves both
  assign ext_a = {{(D_W_ACC-D_W){(SIGNED != 0) && in_a[D_W-1]}}, in_a};
  assign ext_b = {{(D_W_ACC-D_W){(SIGNED != 0) && in_b[D_W-1]}}, in_b};
  assign prod  = ext_a * ext_b;
  assign sum   = {1'b0, acc} + {1'b0, prod};
  assign sum_w = sum[D_W_ACC-1:0];
  always_comb begin
    ovf = (SIGNED != 0)
      ? (acc[D_W_ACC-1] == prod[D_W_ACC-1]) && (sum_w[D_W_ACC-1] != acc[D_W_ACC-1])
      : sum[D_W_ACC];
    clamp = (SIGNED == 0) ? {D_W_ACC{1'b1}}
      : acc[D_W_ACC-1] ? {1'b1, {(D_W_ACC-1){1'b0}}} : {1'b0, {(D_W_ACC-1){1'b1}}};
    acc_add = (ovf && SATURATE != 0) ? clamp : sum_w;
  end
  assign start    = op_valid_in && init;
  assign close    = op_valid_in && state == RUN && (init || flush);
  assign accum    = op_valid_in && state == RUN && !init && !flush;
  assign free     = !out_valid || out_ready;
  assign take_res = free && res_pending;
  assign in_ready = free && !res_pending;
  always_comb begin
    state_nx = state;
    state_nx = start ? RUN : close ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_valid_out <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      acc          <= '0;
      tile_sat     <= 1'b0;
      res_data     <= '0;
      res_sat      <= 1'b0;
      res_pending  <= 1'b0;
      overrun      <= 1'b0;
      out_data     <= '0;
      out_sat      <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_nx;
      op_valid_out <= op_valid_in;
      out_a        <= in_a;
      out_b        <= in_b;
      if (start) begin
        acc      <= prod;
        tile_sat <= 1'b0;
      end else if (accum) begin
        acc      <= acc_add;
        tile_sat <= tile_sat || ovf;
      end
      if (close) begin
        res_data <= acc;
        res_sat  <= tile_sat;
      end
      res_pending <= close || (res_pending && !take_res);
      if (close && res_pending && !take_res) overrun <= 1'b1;
      // Own result has priority over the upstream beat
      if (free) begin
        out_valid <= res_pending || in_valid;
        if (res_pending) begin
          out_data <= res_data;
          out_sat  <= res_sat;
        end else if (in_valid) begin
          out_data <= in_data;
          out_sat  <= in_sat;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_mac_drain.sv
// tb_pe_mac_drain: directed checks of MAC, saturation, drain priority/backpressure, overrun and reset
module tb_pe_mac_drain;
  logic clk = 1'b0;
  logic rst, op_valid_in, init, flush, out_ready, in_valid, in_sat;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic [63:0] in_data;
  logic        m_ova, m_ir, m_os, m_ov, m_orun;
  logic [31:0] m_oa, m_ob;
  logic [63:0] m_od;
  logic        s_ova, s_ir, s_os, s_ov, s_orun;
  logic [7:0]  s_oa, s_ob;
  logic [15:0] s_od;
  logic        w_ova, w_ir, w_os, w_ov, w_orun;
  logic [7:0]  w_oa, w_ob;
  logic [15:0] w_od;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_mac_drain u_m (
    .clk(clk), .rst(rst), .op_valid_in(op_valid_in), .in_a(a), .in_b(b), .init(init), .flush(flush),
    .op_valid_out(m_ova), .out_a(m_oa), .out_b(m_ob), .in_data(in_data), .in_sat(in_sat),
    .in_valid(in_valid), .in_ready(m_ir), .out_data(m_od), .out_sat(m_os), .out_valid(m_ov),
    .out_ready(out_ready), .overrun(m_orun));

  pe_mac_drain #(.D_W(8), .D_W_ACC(16), .SIGNED(0), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst), .op_valid_in(op_valid_in), .in_a(a8), .in_b(b8), .init(init), .flush(flush),
    .op_valid_out(s_ova), .out_a(s_oa), .out_b(s_ob), .in_data(in_data[15:0]), .in_sat(in_sat),
    .in_valid(in_valid), .in_ready(s_ir), .out_data(s_od), .out_sat(s_os), .out_valid(s_ov),
    .out_ready(out_ready), .overrun(s_orun));

  pe_mac_drain #(.D_W(8), .D_W_ACC(16), .SIGNED(0), .SATURATE(0)) u_w (
    .clk(clk), .rst(rst), .op_valid_in(op_valid_in), .in_a(a8), .in_b(b8), .init(init), .flush(flush),
    .op_valid_out(w_ova), .out_a(w_oa), .out_b(w_ob), .in_data(in_data[15:0]), .in_sat(in_sat),
    .in_valid(in_valid), .in_ready(w_ir), .out_data(w_od), .out_sat(w_os), .out_valid(w_ov),
    .out_ready(out_ready), .overrun(w_orun));

  task step;
    @(posedge clk);
    #1;
  endtask

  task op(input logic v, input logic i, input logic f, input logic [31:0] xa, input logic [31:0] xb);
    op_valid_in = v;
    init = i;
    flush = f;
    a = xa;
    b = xb;
    a8 = xa[7:0];
    b8 = xb[7:0];
    step();
  endtask

  task test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++; if ({m_ova, m_oa, m_ob, m_od, m_os, m_ov, m_orun} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got ova=%b a=%0h b=%0h d=%0h s=%b v=%b orun=%b, expected all 0",
               m_ova, m_oa, m_ob, m_od, m_os, m_ov, m_orun); end
    n_chk++; if (m_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", m_ir); end
    n_chk++; if ({s_od, s_ov, w_od, w_ov} !== '0) begin n_fail++;
      $display("FAIL reset_u8: got s=%0h/%b w=%0h/%b expected 0", s_od, s_ov, w_od, w_ov); end
  endtask

  task test_signed_mac;
    op(1, 1, 0, 32'd3, -32'sd4);
    n_chk++; if ({m_ova, m_oa, m_ob} !== {1'b1, 32'd3, 32'hFFFF_FFFC}) begin n_fail++;
      $display("FAIL forward: got v=%b a=%0h b=%0h expected 1/3/fffffffc", m_ova, m_oa, m_ob); end
    op(1, 0, 0, 32'd5, 32'd6);
    op(1, 0, 1, 32'd0, 32'd0);
    n_chk++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL own_latency: got out_valid=%b expected 0", m_ov); end
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od, m_os} !== {1'b1, 64'd18, 1'b0}) begin n_fail++;
      $display("FAIL signed_result: got v=%b d=%0d s=%b expected 1/18/0", m_ov, $signed(m_od), m_os); end
    step();
    n_chk++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", m_ov); end
  endtask

  task test_unsigned_sat;
    op(1, 1, 0, 32'd255, 32'd255);
    op(1, 0, 0, 32'd255, 32'd255);
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({s_ov, s_od, s_os} !== {1'b1, 16'd65535, 1'b1}) begin n_fail++;
      $display("FAIL unsigned_saturate: got v=%b d=%0d s=%b expected 1/65535/1", s_ov, s_od, s_os); end
    n_chk++; if ({w_ov, w_od, w_os} !== {1'b1, 16'd64514, 1'b1}) begin n_fail++;
      $display("FAIL unsigned_wrap: got v=%b d=%0d s=%b expected 1/64514/1", w_ov, w_od, w_os); end
    step();
  endtask

  task test_signed_sat;
    op(1, 1, 0, 32'h8000_0000, 32'h8000_0000);
    op(1, 0, 0, 32'h8000_0000, 32'h8000_0000);
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_od, m_os} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1}) begin n_fail++;
      $display("FAIL signed_saturate: got d=%0h s=%b expected 7fffffffffffffff/1", m_od, m_os); end
    op(1, 1, 0, 32'd1, 32'd1);
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od, m_os} !== {1'b1, 64'd1, 1'b0}) begin n_fail++;
      $display("FAIL sat_cleared: got v=%b d=%0h s=%b expected 1/1/0", m_ov, m_od, m_os); end
    step();
  endtask

  task test_backpressure;
    out_ready = 1'b0;
    op(1, 1, 0, 32'd2, 32'd3);
    op(1, 0, 1, 32'd0, 32'd0);
    in_valid = 1'b1;
    in_data = 64'd7;
    #1;
    n_chk++; if (m_ir !== 1'b0) begin n_fail++; $display("FAIL ready_while_pending: got %b expected 0", m_ir); end
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od} !== {1'b1, 64'd6}) begin n_fail++;
      $display("FAIL own_first: got v=%b d=%0d expected 1/6", m_ov, m_od); end
    step();
    n_chk++; if ({m_ov, m_od, m_ir} !== {1'b1, 64'd6, 1'b0}) begin n_fail++;
      $display("FAIL stall_stable: got v=%b d=%0d ir=%b expected 1/6/0", m_ov, m_od, m_ir); end
    out_ready = 1'b1;
    #1;
    n_chk++; if (m_ir !== 1'b1) begin n_fail++; $display("FAIL ready_on_release: got %b expected 1", m_ir); end
    step();
    in_valid = 1'b0;
    n_chk++; if ({m_ov, m_od} !== {1'b1, 64'd7}) begin n_fail++;
      $display("FAIL upstream_second: got v=%b d=%0d expected 1/7", m_ov, m_od); end
    step();
    n_chk++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL after_upstream: got %b expected 0", m_ov); end
  endtask

  task test_overrun;
    out_ready = 1'b0;
    op(1, 1, 0, 32'd1, 32'd1);
    op(1, 1, 0, 32'd2, 32'd1);
    op(1, 1, 0, 32'd3, 32'd1);
    n_chk++; if (m_orun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b expected 0", m_orun); end
    op(1, 0, 1, 32'd0, 32'd0);
    n_chk++; if ({m_orun, m_ov, m_od} !== {1'b1, 1'b1, 64'd1}) begin n_fail++;
      $display("FAIL overrun_set: got orun=%b v=%b d=%0d expected 1/1/1", m_orun, m_ov, m_od); end
    out_ready = 1'b1;
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od} !== {1'b1, 64'd3}) begin n_fail++;
      $display("FAIL overrun_kept: got v=%b d=%0d expected 1/3", m_ov, m_od); end
    step();
    n_chk++; if ({m_ov, m_orun} !== 2'b01) begin n_fail++;
      $display("FAIL overrun_sticky: got v=%b orun=%b expected 0/1", m_ov, m_orun); end
  endtask

  task test_init_ignored;
    op(0, 1, 0, 32'd3, 32'd3);
    n_chk++; if ({m_ova, m_oa, m_ob} !== {1'b0, 32'd3, 32'd3}) begin n_fail++;
      $display("FAIL fwd_invalid: got v=%b a=%0d b=%0d expected 0/3/3", m_ova, m_oa, m_ob); end
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    step();
    n_chk++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL idle_no_tile: got out_valid=%b expected 0", m_ov); end
    op(1, 1, 0, 32'd2, 32'd2);
    op(0, 1, 0, 32'd100, 32'd100);
    op(1, 0, 0, 32'd1, 32'd1);
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od} !== {1'b1, 64'd5}) begin n_fail++;
      $display("FAIL run_init_ignored: got v=%b d=%0d expected 1/5", m_ov, m_od); end
    step();
  endtask

  task test_reset_mid;
    op(1, 1, 0, 32'd4, 32'd4);
    op(1, 0, 0, 32'd1, 32'd1);
    rst = 1'b1;
    op(1, 0, 0, 32'd7, 32'd7);
    rst = 1'b0;
    n_chk++; if ({m_ova, m_oa, m_ob, m_ov, m_od, m_orun} !== '0) begin n_fail++;
      $display("FAIL reset_mid: got ova=%b a=%0d b=%0d v=%b d=%0d orun=%b expected all 0",
               m_ova, m_oa, m_ob, m_ov, m_od, m_orun); end
    op(1, 0, 0, 32'd1, 32'd1);
    op(1, 1, 0, 32'd2, 32'd5);
    op(1, 0, 0, 32'd1, 32'd1);
    n_chk++; if (m_ov !== 1'b0) begin n_fail++; $display("FAIL reset_no_partial: got %b expected 0", m_ov); end
    op(1, 0, 1, 32'd0, 32'd0);
    op(0, 0, 0, 32'd0, 32'd0);
    n_chk++; if ({m_ov, m_od, m_os} !== {1'b1, 64'd11, 1'b0}) begin n_fail++;
      $display("FAIL post_reset_tile: got v=%b d=%0d s=%b expected 1/11/0", m_ov, m_od, m_os); end
  endtask

  initial begin
    rst = 1'b1;
    op_valid_in = 1'b0;
    init = 1'b0;
    flush = 1'b0;
    a = '0;
    b = '0;
    a8 = '0;
    b8 = '0;
    in_data = '0;
    in_sat = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_signed_mac();
    test_unsigned_sat();
    test_signed_sat();
    test_backpressure();
    test_overrun();
    test_init_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
